// File: rtl/multicycle_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I-subset core: FSM states,
// major opcodes and the datapath select codes seen by datapath and ALU decoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_ILLEGAL  = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Where DECODE sends each major opcode; anything unrecognised traps.
   function automatic state_t decode_next(input logic [6:0] opcode);
      state_t nxt;
      case (opcode)
         OP_LOAD, OP_STORE: nxt = S_MEMADR;
         OP_RTYPE:          nxt = S_EXECR;
         OP_ITYPE:          nxt = S_EXECI;
         OP_BRANCH:         nxt = S_BEQ;
         default:           nxt = S_ILLEGAL;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flags in, strobes and selects out.
interface multicycle_ctrl_if #(parameter int CNT_W = 16);

   logic [31:0]      instr;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             ir_write;
   logic             adr_src;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       result_src;
   logic             instr_done;
   logic             trap;
   logic [CNT_W-1:0] retired_cnt;
   logic [3:0]       state;

   modport master (
      input  instr, zero, mem_ready,
      output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
      output alu_src_a, alu_src_b, alu_op, result_src,
      output instr_done, trap, retired_cnt, state
   );

   modport slave (
      output instr, zero, mem_ready,
      input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
      input  alu_src_a, alu_src_b, alu_op, result_src,
      input  instr_done, trap, retired_cnt, state
   );

endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Moore output map: state (plus zero / mem_ready qualifiers) to datapath
// strobes and selects. Purely combinational.
module ctrl_out_decode
   import ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       trap
);

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALUOUT;
      trap       = 1'b0;
      case (state)
         // Instruction fetch and PC+4 share the cycle the memory completes.
         S_FETCH: begin
            mem_read   = 1'b1;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            mem_read = 1'b1;
            adr_src  = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
         end
         // Branch target was parked in the ALU result register during DECODE.
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            pc_write   = zero;
         end
         S_ILLEGAL: trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register, next-state logic, retire pulse and
// retired-instruction counter; output decoding lives in ctrl_out_decode.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.master  bus
);

   state_t           state_q;
   state_t           state_d;
   logic             retire;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;
   logic [6:0]       opcode;

   logic       pc_write_raw;
   logic       ir_write_raw;
   logic       mem_read_raw;
   logic       mem_write_raw;
   logic       reg_write_raw;

   assign opcode = bus.instr[6:0];

   always_comb begin
      state_d = S_FETCH;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_d = decode_next(opcode);
         S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWRITE: begin
            state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            retire  = bus.mem_ready;
         end
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_ALUWB, S_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= retire;
         cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, retire};
      end
   end

   ctrl_out_decode u_out_decode (
      .state      (state_q),
      .zero       (bus.zero),
      .mem_ready  (bus.mem_ready),
      .pc_write   (pc_write_raw),
      .ir_write   (ir_write_raw),
      .adr_src    (bus.adr_src),
      .mem_read   (mem_read_raw),
      .mem_write  (mem_write_raw),
      .reg_write  (reg_write_raw),
      .alu_src_a  (bus.alu_src_a),
      .alu_src_b  (bus.alu_src_b),
      .alu_op     (bus.alu_op),
      .result_src (bus.result_src),
      .trap       (bus.trap)
   );

   // Architectural side effects are suppressed for the whole reset cycle.
   assign bus.pc_write  = pc_write_raw  & ~reset;
   assign bus.ir_write  = ir_write_raw  & ~reset;
   assign bus.mem_read  = mem_read_raw  & ~reset;
   assign bus.mem_write = mem_write_raw & ~reset;
   assign bus.reg_write = reg_write_raw & ~reset;

   assign bus.instr_done  = done_q;
   assign bus.retired_cnt = cnt_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe checks over each
// instruction class, stalls, reset abort, illegal trap and counter wrap.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   localparam logic [31:0] I_ADDI = 32'h00400093;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SW   = 32'h00100023;
   localparam logic [31:0] I_LW   = 32'h00002203;
   localparam logic [31:0] I_BEQ  = 32'h40210463;
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   multicycle_ctrl_if #(.CNT_W(16)) bus ();
   multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

   assign bus4.instr     = bus.instr;
   assign bus4.zero      = bus.zero;
   assign bus4.mem_ready = bus.mem_ready;

   multicycle_ctrl #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // strobes = {pc_write, ir_write, mem_read, mem_write, reg_write}
   task automatic cyc(input string tag, input state_t st, input logic [4:0] stb);
      chk({tag, "_state"}, {28'd0, bus.state}, {28'd0, st});
      chk({tag, "_strobes"}, {27'd0, bus.pc_write, bus.ir_write, bus.mem_read,
                              bus.mem_write, bus.reg_write}, {27'd0, stb});
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      bus.instr = 32'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b0;
      next_cycle();
      next_cycle();
      bus.mem_ready = 1'b1;
      #1;
      cyc("rst", S_FETCH, 5'b00000);
      chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
      chk("rst_done", 32'(bus.instr_done), 32'd0);
      chk("rst_trap", 32'(bus.trap), 32'd0);

      // addi: FETCH DECODE EXECI ALUWB
      reset = 1'b0;
      bus.instr = I_ADDI;
      #1;
      cyc("addi_f", S_FETCH, 5'b11100);
      chk("addi_f_srcb", 32'(bus.alu_src_b), 32'd2);
      chk("addi_f_res", 32'(bus.result_src), 32'd2);
      next_cycle(); #1;
      cyc("addi_d", S_DECODE, 5'b00000);
      chk("addi_d_srca", 32'(bus.alu_src_a), 32'd1);
      chk("addi_d_srcb", 32'(bus.alu_src_b), 32'd1);
      next_cycle(); #1;
      cyc("addi_x", S_EXECI, 5'b00000);
      chk("addi_x_op", 32'(bus.alu_op), 32'd2);
      next_cycle(); #1;
      cyc("addi_wb", S_ALUWB, 5'b00001);
      chk("addi_wb_res", 32'(bus.result_src), 32'd0);
      chk("addi_wb_done", 32'(bus.instr_done), 32'd0);

      // add with three stalled fetch cycles
      next_cycle();
      bus.instr = I_ADD;
      bus.mem_ready = 1'b0;
      #1;
      chk("addi_done", 32'(bus.instr_done), 32'd1);
      chk("addi_cnt", 32'(bus.retired_cnt), 32'd1);
      cyc("add_f0", S_FETCH, 5'b00100);
      next_cycle(); #1;
      cyc("add_f1", S_FETCH, 5'b00100);
      chk("add_f1_done", 32'(bus.instr_done), 32'd0);
      next_cycle(); #1;
      cyc("add_f2", S_FETCH, 5'b00100);
      next_cycle();
      bus.mem_ready = 1'b1;
      #1;
      cyc("add_f3", S_FETCH, 5'b11100);
      next_cycle(); #1;
      cyc("add_d", S_DECODE, 5'b00000);
      next_cycle(); #1;
      cyc("add_x", S_EXECR, 5'b00000);
      chk("add_x_op", 32'(bus.alu_op), 32'd2);
      chk("add_x_srca", 32'(bus.alu_src_a), 32'd2);
      chk("add_x_srcb", 32'(bus.alu_src_b), 32'd0);
      next_cycle(); #1;
      cyc("add_wb", S_ALUWB, 5'b00001);

      // sw then lw
      next_cycle();
      bus.instr = I_SW;
      #1;
      chk("add_done", 32'(bus.instr_done), 32'd1);
      chk("add_cnt", 32'(bus.retired_cnt), 32'd2);
      cyc("sw_f", S_FETCH, 5'b11100);
      next_cycle(); #1;
      cyc("sw_d", S_DECODE, 5'b00000);
      next_cycle(); #1;
      cyc("sw_a", S_MEMADR, 5'b00000);
      chk("sw_a_srca", 32'(bus.alu_src_a), 32'd2);
      next_cycle(); #1;
      cyc("sw_w", S_MEMWRITE, 5'b00010);
      chk("sw_w_adr", 32'(bus.adr_src), 32'd1);
      next_cycle();
      bus.instr = I_LW;
      #1;
      chk("sw_done", 32'(bus.instr_done), 32'd1);
      chk("sw_cnt", 32'(bus.retired_cnt), 32'd3);
      cyc("lw_f", S_FETCH, 5'b11100);
      next_cycle(); #1;
      cyc("lw_d", S_DECODE, 5'b00000);
      next_cycle(); #1;
      cyc("lw_a", S_MEMADR, 5'b00000);
      next_cycle(); #1;
      cyc("lw_r", S_MEMREAD, 5'b00100);
      chk("lw_r_adr", 32'(bus.adr_src), 32'd1);
      next_cycle(); #1;
      cyc("lw_wb", S_MEMWB, 5'b00001);
      chk("lw_wb_res", 32'(bus.result_src), 32'd1);

      // beq taken, then not taken
      next_cycle();
      bus.instr = I_BEQ;
      bus.zero = 1'b1;
      #1;
      chk("lw_done", 32'(bus.instr_done), 32'd1);
      chk("lw_cnt", 32'(bus.retired_cnt), 32'd4);
      cyc("beq1_f", S_FETCH, 5'b11100);
      next_cycle(); #1;
      cyc("beq1_d", S_DECODE, 5'b00000);
      next_cycle(); #1;
      cyc("beq1_b", S_BEQ, 5'b10000);
      chk("beq1_op", 32'(bus.alu_op), 32'd1);
      next_cycle();
      bus.zero = 1'b0;
      #1;
      chk("beq1_cnt", 32'(bus.retired_cnt), 32'd5);
      cyc("beq0_f", S_FETCH, 5'b11100);
      next_cycle(); #1;
      cyc("beq0_d", S_DECODE, 5'b00000);
      next_cycle(); #1;
      cyc("beq0_b", S_BEQ, 5'b00000);

      // lw aborted by reset while stalled in MEMREAD
      next_cycle();
      bus.instr = I_LW;
      #1;
      chk("beq0_done", 32'(bus.instr_done), 32'd1);
      chk("beq0_cnt", 32'(bus.retired_cnt), 32'd6);
      next_cycle();
      next_cycle();
      next_cycle();
      bus.mem_ready = 1'b0;
      #1;
      cyc("abort_r0", S_MEMREAD, 5'b00100);
      next_cycle();
      reset = 1'b1;
      #1;
      cyc("abort_r1", S_MEMREAD, 5'b00000);
      next_cycle();
      reset = 1'b0;
      #1;
      cyc("abort_f", S_FETCH, 5'b00100);
      chk("abort_done", 32'(bus.instr_done), 32'd0);
      chk("abort_cnt", 32'(bus.retired_cnt), 32'd0);

      // sw with one stalled MEMWRITE cycle: retires only on the ready cycle
      bus.instr = I_SW;
      bus.mem_ready = 1'b1;
      next_cycle();
      next_cycle();
      next_cycle();
      bus.mem_ready = 1'b0;
      #1;
      cyc("sws_w0", S_MEMWRITE, 5'b00010);
      next_cycle();
      bus.mem_ready = 1'b1;
      #1;
      cyc("sws_w1", S_MEMWRITE, 5'b00010);
      chk("sws_w1_done", 32'(bus.instr_done), 32'd0);
      next_cycle();
      bus.instr = I_ILL;
      #1;
      chk("sws_done", 32'(bus.instr_done), 32'd1);
      chk("sws_cnt", 32'(bus.retired_cnt), 32'd1);

      // illegal opcode traps and stays trapped
      next_cycle(); #1;
      cyc("ill_d", S_DECODE, 5'b00000);
      for (int i = 0; i < 11; i++) begin
         next_cycle();
         bus.mem_ready = i[0];
         #1;
         cyc("ill_hold", S_ILLEGAL, 5'b00000);
         chk("ill_trap", 32'(bus.trap), 32'd1);
         chk("ill_cnt", 32'(bus.retired_cnt), 32'd1);
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      bus.instr = I_BEQ;
      #1;
      cyc("ill_rst", S_FETCH, 5'b11100);
      chk("ill_rst_trap", 32'(bus.trap), 32'd0);
      chk("ill_rst_cnt", 32'(bus.retired_cnt), 32'd0);

      // counter wrap on the narrow instance: 15 beqs, then one more
      for (int i = 0; i < 15; i++) begin
         next_cycle();
         next_cycle();
         next_cycle();
      end
      #1;
      chk("wrap_pre4", 32'(bus4.retired_cnt), 32'd15);
      chk("wrap_pre16", 32'(bus.retired_cnt), 32'd15);
      next_cycle();
      next_cycle();
      next_cycle();
      #1;
      chk("wrap_post4", 32'(bus4.retired_cnt), 32'd0);
      chk("wrap_post4_done", 32'(bus4.instr_done), 32'd1);
      chk("wrap_post16", 32'(bus.retired_cnt), 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM that sequences the shared RV32I-subset datapath (single ALU, unified memory port, register file) over multiple cycles per instruction. It decodes opcode/funct fields of the held instruction, drives all datapath selects and write strobes, waits on a memory-ready handshake and resolves beq using the ALU zero flag. It sits beside the datapath inside the top-level core and also provides a retired-instruction counter and an illegal-opcode trap.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
instr  input  32  contents of instruction register (opcode [6:0], funct3 [14:12], funct7 [31:25])
zero  input  1  ALU zero flag
mem_ready  input  1  memory port completed current access this cycle
pc_write  output  1  PC load strobe
ir_write  output  1  instruction register load strobe
adr_src  output  1  memory address: 0=PC, 1=ALU result register
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write strobe
alu_src_a  output  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  output  2  00=rs2, 01=imm, 10=const 4
alu_op  output  2  00=add, 01=sub, 10=decode funct3/funct7
result_src  output  2  00=ALU result register, 01=memory data, 10=ALU direct
instr_done  output  1  one-cycle pulse when an instruction retires
trap  output  1  illegal opcode seen; sticky until reset
retired_cnt  output  CNT_W  count of retired instructions
state  output  4  current state encoding, for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, ILLEGAL. Outputs are Moore, decoded from state; strobes not listed below are 0.
- Reset: on any edge with reset=1, state=FETCH, retired_cnt=0, trap=0, instr_done=0. While reset=1, all write/request strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced 0 combinationally. Reset mid-instruction abandons the instruction with no retire.
- FETCH: mem_read=1, adr_src=0. ir_write and pc_write equal mem_ready, with alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10 (PC<=PC+4). Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALU result register). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - anything else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then goes to FETCH (retire).
- MEMWRITE: mem_write=1, adr_src=1. Holds until mem_ready, then goes to FETCH (retire on the mem_ready cycle).
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then goes to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, then goes to FETCH (retire).
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, then goes to FETCH (retire, whether the branch is taken or not).
- ILLEGAL: trap=1, all strobes 0, no retire. Absorbing state until reset.
- Retire: instr_done is registered and is 1 for exactly the cycle after the retiring transition. retired_cnt increments on the same edge that sets instr_done and wraps from all-ones to 0.
- Latencies with mem_ready tied to 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- State encoding lives in the package. Unused encodings go to FETCH on the next edge.

Decomposition:
- Shared package ctrl_pkg holds: state enum/localparams; opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH); the alu_src_a, alu_src_b, alu_op and result_src encodings. The datapath and ALU decoder import the same package.
- One sub-module is natural: ctrl_out_decode, a purely combinational mapping from state (plus zero and mem_ready) to strobes and selects. The FSM registers and counter stay in multicycle_ctrl.

Test Plan:
- Reset held 2 cycles, then instr=0x00400093 (addi x1,x0,4), mem_ready=1 -> states FETCH, DECODE, EXECI, ALUWB; reg_write=1 in cycle 4 only; instr_done pulse; retired_cnt=1.
- instr=0x002081B3 (add) with mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles, no ir_write until the mem_ready cycle; alu_op=10 and alu_src_b=00 in EXECR; total 7 cycles.
- instr=0x00100023 (sw) followed by 0x00002203 (lw) -> sw asserts mem_write in MEMWRITE (4 cycles, reg_write never 1); lw asserts result_src=01 and reg_write in MEMWB (5 cycles); retired_cnt advances by 2.
- instr=0x40210463 (beq): once with zero=1 -> pc_write=1 in BEQ; once with zero=0 -> pc_write=0 in BEQ; each 3 cycles, each retires.
- instr=0x0000007F (illegal opcode) -> DECODE goes to ILLEGAL, trap=1 and held, all strobes 0 for 10+ cycles; reset -> FETCH, trap=0, retired_cnt=0.
- reset=1 asserted during MEMREAD -> strobes 0 in that cycle, FETCH on next edge, no instr_done. Separately, preload via 2^16 retirements (CNT_W=16) -> retired_cnt wraps 0xFFFF to 0x0000.
